// File: rtl/adder_pkg.sv
// Shared types and constants for the sequential multi-operand adder.
// State encoding, mode constants and the accumulator sizing helper live here.
package adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ADD  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Wide enough that the sum of num_ops full-scale operands cannot wrap.
    function automatic int acc_width(input int width, input int num_ops);
        return width + $clog2(num_ops);
    endfunction

endpackage

// File: rtl/operand_regfile.sv
// Operand storage: synchronous write, asynchronous read, no reset on contents.
module operand_regfile #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/multi_operand_adder_seq.sv
// Collects NUM_OPS operands over a valid/ready stream, then sums them one per cycle
// through a single shared adder and presents the result with a one-cycle strobe.
module multi_operand_adder_seq
    import adder_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NUM_OPS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic             mode,
    input  logic             abort,
    input  logic             op_valid,
    input  logic [WIDTH-1:0] op_data,
    output logic             op_ready,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             result_valid
);

    localparam int ACC_W = acc_width(WIDTH, NUM_OPS);
    localparam int IDX_W = $clog2(NUM_OPS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OPS - 1);

    state_t             state_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [ACC_W-1:0]   acc_reg;
    logic               mode_reg;
    logic               op_ready_reg;
    logic               busy_reg;
    logic [WIDTH-1:0]   result_reg;
    logic               overflow_reg;
    logic               result_valid_reg;

    logic               handshake;
    logic               idx_last;
    logic [WIDTH-1:0]   rd_data;
    logic [ACC_W-1:0]   sum_next;
    logic               sum_ovf;
    logic [WIDTH-1:0]   sat_value;

    // op_ready_reg is only ever high in LOAD, so it doubles as the write qualifier.
    assign handshake = op_valid & op_ready_reg;
    assign idx_last  = (idx_reg == IDX_LAST);

    operand_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (NUM_OPS),
        .AW    (IDX_W)
    ) u_regfile (
        .clk   (clk),
        .we    (handshake),
        .waddr (idx_reg),
        .wdata (op_data),
        .raddr (idx_reg),
        .rdata (rd_data)
    );

    assign sum_next  = acc_reg + ACC_W'(rd_data);
    assign sum_ovf   = |sum_next[ACC_W-1:WIDTH];
    assign sat_value = sum_ovf ? {WIDTH{1'b1}} : sum_next[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_IDLE;
            idx_reg          <= '0;
            acc_reg          <= '0;
            mode_reg         <= MODE_WRAP;
            op_ready_reg     <= 1'b0;
            busy_reg         <= 1'b0;
            result_reg       <= '0;
            overflow_reg     <= 1'b0;
            result_valid_reg <= 1'b0;
        end else begin
            result_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (go && !abort) begin
                        mode_reg     <= mode;
                        idx_reg      <= '0;
                        acc_reg      <= '0;
                        op_ready_reg <= 1'b1;
                        busy_reg     <= 1'b1;
                        state_reg    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        op_ready_reg <= 1'b0;
                        busy_reg     <= 1'b0;
                        state_reg    <= ST_IDLE;
                    end else if (handshake) begin
                        if (idx_last) begin
                            idx_reg      <= '0;
                            op_ready_reg <= 1'b0;
                            state_reg    <= ST_ADD;
                        end else begin
                            idx_reg <= idx_reg + IDX_W'(1);
                        end
                    end
                end
                ST_ADD: begin
                    if (abort) begin
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else begin
                        acc_reg <= sum_next;
                        if (idx_last) begin
                            // Final sum is registered straight into the outputs shown in DONE.
                            idx_reg          <= '0;
                            result_reg       <= (mode_reg == MODE_SAT) ? sat_value : sum_next[WIDTH-1:0];
                            overflow_reg     <= sum_ovf;
                            result_valid_reg <= 1'b1;
                            state_reg        <= ST_DONE;
                        end else begin
                            idx_reg <= idx_reg + IDX_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    op_ready_reg <= 1'b0;
                    busy_reg     <= 1'b0;
                    state_reg    <= ST_IDLE;
                end
            endcase
        end
    end

    assign op_ready     = op_ready_reg;
    assign busy         = busy_reg;
    assign result       = result_reg;
    assign overflow     = overflow_reg;
    assign result_valid = result_valid_reg;

endmodule

// File: tb/tb_multi_operand_adder_seq.sv
// Directed bench for multi_operand_adder_seq: default 8-bit/4-operand instance plus a
// 4-bit/3-operand instance, all expectations hand-computed.
module tb_multi_operand_adder_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       go = 1'b0, mode = 1'b0, abort = 1'b0, op_valid = 1'b0;
    logic [7:0] op_data = '0;
    logic       op_ready, busy, overflow, result_valid;
    logic [7:0] result;

    logic       go_b = 1'b0, mode_b = 1'b0, abort_b = 1'b0, op_valid_b = 1'b0;
    logic [3:0] op_data_b = '0;
    logic       op_ready_b, busy_b, overflow_b, result_valid_b;
    logic [3:0] result_b;

    int total = 0;
    int bad   = 0;

    multi_operand_adder_seq #(.WIDTH(8), .NUM_OPS(4)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .mode(mode), .abort(abort),
        .op_valid(op_valid), .op_data(op_data), .op_ready(op_ready), .busy(busy),
        .result(result), .overflow(overflow), .result_valid(result_valid)
    );

    multi_operand_adder_seq #(.WIDTH(4), .NUM_OPS(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .go(go_b), .mode(mode_b), .abort(abort_b),
        .op_valid(op_valid_b), .op_data(op_data_b), .op_ready(op_ready_b), .busy(busy_b),
        .result(result_b), .overflow(overflow_b), .result_valid(result_valid_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Mode is flipped right after go is accepted; the latched value must be used.
    task automatic start(input logic m);
        go   = 1'b1;
        mode = m;
        tick();
        go   = 1'b0;
        mode = ~m;
        check("start_busy", busy, 1);
        check("start_ready", op_ready, 1);
    endtask

    task automatic feed(input logic [7:0] v, input int gap, input logic poke_go);
        for (int g = 0; g < gap; g++) begin
            op_valid = 1'b0;
            op_data  = 8'hff;
            go       = poke_go;
            tick();
            check("gap_ready", op_ready, 1);
            check("gap_busy", busy, 1);
        end
        go       = 1'b0;
        op_valid = 1'b1;
        op_data  = v;
        tick();
        op_valid = 1'b0;
    endtask

    task automatic finish_run(input string tag, input int exp_lat, input logic [7:0] exp_res,
                              input logic exp_ovf);
        int cyc = 0;
        while (!result_valid && cyc < 40) begin
            check({tag, "_add_ready"}, op_ready, 0);
            tick();
            cyc++;
        end
        check({tag, "_lat"}, cyc, exp_lat);
        check({tag, "_rv"}, result_valid, 1);
        check({tag, "_res"}, result, exp_res);
        check({tag, "_ovf"}, overflow, exp_ovf);
        check({tag, "_done_busy"}, busy, 1);
        tick();
        check({tag, "_rv_pulse"}, result_valid, 0);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_hold"}, result, exp_res);
    endtask

    task automatic run_b(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic m, input logic [3:0] exp_res,
                         input logic exp_ovf);
        logic [3:0] ops [3];
        int cyc = 0;
        ops[0] = a; ops[1] = b; ops[2] = c;
        go_b   = 1'b1;
        mode_b = m;
        tick();
        go_b   = 1'b0;
        mode_b = ~m;
        for (int i = 0; i < 3; i++) begin
            op_valid_b = 1'b1;
            op_data_b  = ops[i];
            tick();
        end
        op_valid_b = 1'b0;
        while (!result_valid_b && cyc < 40) begin
            tick();
            cyc++;
        end
        check({tag, "_lat"}, cyc, 3);
        check({tag, "_res"}, result_b, exp_res);
        check({tag, "_ovf"}, overflow_b, exp_ovf);
        tick();
        check({tag, "_idle"}, busy_b, 0);
    endtask

    initial begin
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_ready", op_ready, 0);
        check("rst_result", result, 0);
        check("rst_ovf", overflow, 0);
        check("rst_rv", result_valid, 0);
        rst_n = 1'b1;
        tick();

        // go together with abort in IDLE: stays idle
        go = 1'b1; abort = 1'b1;
        tick();
        go = 1'b0; abort = 1'b0;
        check("goabort_busy", busy, 0);
        check("goabort_ready", op_ready, 0);

        // 10+20+30+40, back to back: result_valid in cycle 9 after go
        start(1'b0);
        feed(8'd10, 0, 1'b0); feed(8'd20, 0, 1'b0); feed(8'd30, 0, 1'b0); feed(8'd40, 0, 1'b0);
        finish_run("t1", 4, 8'd100, 1'b0);

        // abort in the second ADD cycle, with a go pulse while busy
        start(1'b0);
        feed(8'd1, 0, 1'b0); feed(8'd2, 0, 1'b0); feed(8'd3, 0, 1'b0); feed(8'd4, 0, 1'b0);
        tick();
        abort = 1'b1; go = 1'b1;
        tick();
        abort = 1'b0; go = 1'b0;
        check("t4_busy", busy, 0);
        check("t4_ready", op_ready, 0);
        check("t4_rv", result_valid, 0);
        check("t4_res", result, 100);
        check("t4_ovf", overflow, 0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("t4_quiet_rv", result_valid, 0);
            check("t4_quiet_busy", busy, 0);
        end

        // abort coincident with the final LOAD handshake
        start(1'b0);
        feed(8'd9, 0, 1'b0); feed(8'd9, 0, 1'b0); feed(8'd9, 0, 1'b0);
        op_valid = 1'b1; op_data = 8'd9; abort = 1'b1;
        tick();
        op_valid = 1'b0; abort = 1'b0;
        check("abl_busy", busy, 0);
        check("abl_ready", op_ready, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("abl_rv", result_valid, 0);
        end
        check("abl_res", result, 100);

        // 200+100+50+10 = 360: wrap gives 104, saturate gives 255
        start(1'b0);
        feed(8'd200, 0, 1'b0); feed(8'd100, 0, 1'b0); feed(8'd50, 0, 1'b0); feed(8'd10, 0, 1'b0);
        finish_run("t2w", 4, 8'd104, 1'b1);
        start(1'b1);
        feed(8'd200, 0, 1'b0); feed(8'd100, 0, 1'b0); feed(8'd50, 0, 1'b0); feed(8'd10, 0, 1'b0);
        finish_run("t2s", 4, 8'd255, 1'b1);

        // 1,2,3,4 with 3-cycle valid gaps and go pulses in the gaps
        start(1'b0);
        feed(8'd1, 0, 1'b0); feed(8'd2, 3, 1'b1); feed(8'd3, 3, 1'b1); feed(8'd4, 3, 1'b1);
        finish_run("t3", 4, 8'd10, 1'b0);

        // reset mid-LOAD clears everything immediately
        start(1'b1);
        feed(8'd7, 0, 1'b0); feed(8'd8, 0, 1'b0);
        rst_n = 1'b0;
        #2;
        check("t5_busy", busy, 0);
        check("t5_ready", op_ready, 0);
        check("t5_res", result, 0);
        check("t5_ovf", overflow, 0);
        check("t5_rv", result_valid, 0);
        tick();
        rst_n = 1'b1;
        tick();
        start(1'b0);
        feed(8'd5, 0, 1'b0); feed(8'd5, 0, 1'b0); feed(8'd5, 0, 1'b0); feed(8'd5, 0, 1'b0);
        finish_run("t5", 4, 8'd20, 1'b0);

        // WIDTH=4, NUM_OPS=3: 45 saturates to 15, wraps to 13
        run_b("t6s", 4'd15, 4'd15, 4'd15, 1'b1, 4'd15, 1'b1);
        run_b("t6w", 4'd15, 4'd15, 4'd15, 1'b0, 4'd13, 1'b1);
        run_b("t6n", 4'd1, 4'd2, 4'd3, 1'b1, 4'd6, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
